hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_md_timer.sv | 30 +++
 rtl/hazard_ctrl.sv | 109 ++++++++++
 tb/tb_hazard_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the forwarding-select encoding, the mul/div FSM states and the forwarding priority helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN    = 1'b0,
    MDWAIT = 1'b1
  } hz_state_t;

  // The M stage holds the younger result, so it wins over W.
  function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
    if (hit_m) return FWD_MEM;
    if (hit_w) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_md_timer.sv
// Down-counter for the remaining E-stage cycles of a multi-cycle mul/div op.
// load arms it with LATENCY-2; it counts down while busy and never goes below zero.
module hazard_md_timer #(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (busy && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush and mul/div stall.
// Define HAZARD_MULDIV_EN to build the multi-cycle mul/div FSM; without it MulDivStartE is ignored.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int MULDIV_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  LoadE,
  input  logic                  PCSrcE,
  input  logic                  MulDivStartE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  MulDivBusy
);

  logic m_valid;
  logic w_valid;
  logic load_use;
  logic md_active;

  // Forwarding stays live through reset; register x0 is never a forwarding source.
  assign m_valid   = RegWriteM && (RdM != '0);
  assign w_valid   = RegWriteW && (RdW != '0);
  assign ForwardAE = fwd_pick(m_valid && (RdM == Rs1E), w_valid && (RdW == Rs1E));
  assign ForwardBE = fwd_pick(m_valid && (RdM == Rs2E), w_valid && (RdW == Rs2E));

  assign load_use = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

`ifdef HAZARD_MULDIV_EN
  hz_state_t state;
  logic      md_start;
  logic      md_done;

  assign md_start  = (MULDIV_LATENCY > 1) && (state == RUN) && MulDivStartE;
  assign md_active = md_start || (state == MDWAIT);

  hazard_md_timer #(
    .LATENCY(MULDIV_LATENCY)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (md_start),
    .busy (state == MDWAIT),
    .done (md_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (md_start) state <= MDWAIT;
        MDWAIT:  if (md_done) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end
`else
  logic unused_md;

  assign md_active = 1'b0;
  assign unused_md = &{1'b0, clk, MulDivStartE, MULDIV_LATENCY[0]};
`endif

  // Priority: reset, then an occupied E stage, then branch over load-use.
  always_comb begin
    StallF     = load_use && !PCSrcE;
    StallD     = load_use && !PCSrcE;
    StallE     = 1'b0;
    FlushD     = PCSrcE;
    FlushE     = PCSrcE || load_use;
    FlushM     = 1'b0;
    MulDivBusy = 1'b0;
    if (rst) begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
    end else if (md_active) begin
      StallF     = 1'b1;
      StallD     = 1'b1;
      StallE     = 1'b1;
      FlushD     = 1'b0;
      FlushE     = 1'b0;
      FlushM     = 1'b1;
      MulDivBusy = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized cycles against a behavioural model.
// Honours HAZARD_MULDIV_EN so the same bench covers both builds.
module tb_hazard_ctrl;

  localparam int AW  = 5;
  localparam int LAT = 4;
`ifdef HAZARD_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, LoadE, PCSrcE, MulDivStartE;
  logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivBusy;
  logic [1:0]    ForwardAE, ForwardBE;

  int tests_run    = 0;
  int tests_failed = 0;
  int busy_left    = 0;
  int busy_seen    = 0;

  hazard_ctrl #(
    .REG_ADDR_W     (AW),
    .MULDIV_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .RdE          (RdE),
    .RdM          (RdM),
    .RdW          (RdW),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .LoadE        (LoadE),
    .PCSrcE       (PCSrcE),
    .MulDivStartE (MulDivStartE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushM       (FlushM),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .MulDivBusy   (MulDivBusy)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int fwdModel(input logic we_m, input logic [AW-1:0] rd_m,
                                  input logic we_w, input logic [AW-1:0] rd_w,
                                  input logic [AW-1:0] rs);
    if (we_m && rd_m != 0 && rd_m == rs) return 2;
    if (we_w && rd_w != 0 && rd_w == rs) return 1;
    return 0;
  endfunction

  task automatic applyStimulus(input logic r, input logic [AW-1:0] rs1d, input logic [AW-1:0] rs2d,
                               input logic [AW-1:0] rs1e, input logic [AW-1:0] rs2e,
                               input logic [AW-1:0] rde, input logic [AW-1:0] rdm, input logic [AW-1:0] rdw,
                               input logic wem, input logic wew, input logic lde,
                               input logic br, input logic mds);
    rst = r; Rs1D = rs1d; Rs2D = rs2d; Rs1E = rs1e; Rs2E = rs2e;
    RdE = rde; RdM = rdm; RdW = rdw;
    RegWriteM = wem; RegWriteW = wew; LoadE = lde; PCSrcE = br; MulDivStartE = mds;
  endtask

  // Check every output against the model for the current inputs, then clock and advance the model.
  task automatic runCycle();
    bit lu, md;
    bit e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_bz;
    #2;
    lu = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    md = MD_EN && (busy_left > 0 || (MulDivStartE && LAT > 1));
    if (rst) begin
      {e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_bz} = 7'b000_1110;
    end else if (md) begin
      {e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_bz} = 7'b111_0011;
    end else begin
      e_sf = lu && !PCSrcE;
      e_sd = e_sf;
      e_se = 1'b0;
      e_fd = PCSrcE;
      e_fe = PCSrcE || lu;
      e_fm = 1'b0;
      e_bz = 1'b0;
    end
    checkOutput("ForwardAE", 8'(ForwardAE), 8'(fwdModel(RegWriteM, RdM, RegWriteW, RdW, Rs1E)));
    checkOutput("ForwardBE", 8'(ForwardBE), 8'(fwdModel(RegWriteM, RdM, RegWriteW, RdW, Rs2E)));
    checkOutput("StallF", 8'(StallF), 8'(e_sf));
    checkOutput("StallD", 8'(StallD), 8'(e_sd));
    checkOutput("StallE", 8'(StallE), 8'(e_se));
    checkOutput("FlushD", 8'(FlushD), 8'(e_fd));
    checkOutput("FlushE", 8'(FlushE), 8'(e_fe));
    checkOutput("FlushM", 8'(FlushM), 8'(e_fm));
    checkOutput("MulDivBusy", 8'(MulDivBusy), 8'(e_bz));
    if (MulDivBusy === 1'b1) busy_seen++;
    @(posedge clk);
    if (rst) busy_left = 0;
    else if (busy_left > 0) busy_left--;
    else if (MD_EN && MulDivStartE && LAT > 1) busy_left = LAT - 1;
    #1;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    // Reset values, with forwarding still active under reset.
    applyStimulus(1, 0, 0, 3, 4, 0, 3, 4, 1, 1, 0, 0, 0);
    runCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();

    // M wins over W; with RdM=0 the W stage forwards.
    applyStimulus(0, 0, 0, 5, 5, 0, 5, 5, 1, 1, 0, 0, 0);
    runCycle();
    checkOutput("fwd_mem_prio", 8'(ForwardAE), 8'd2);
    applyStimulus(0, 0, 0, 5, 5, 0, 0, 5, 1, 1, 0, 0, 0);
    runCycle();
    checkOutput("fwd_wb_rdm0", 8'(ForwardAE), 8'd1);

    // Load-use bubble on x7, then release.
    applyStimulus(0, 1, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0);
    runCycle();
    applyStimulus(0, 1, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    // Load on x0 never stalls.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    runCycle();

    // Branch together with load-use: branch wins.
    applyStimulus(0, 7, 2, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0);
    runCycle();

    // Mul/div occupancy with a branch in cycle 2.
    busy_seen = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    runCycle();
`ifdef HAZARD_MULDIV_EN
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`else
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`endif
    for (int i = 0; i < 4; i++) runCycle();
    checkOutput("md_busy_cycles", 8'(busy_seen), MD_EN ? 8'(LAT) : 8'd0);

    // Reset in the middle of MDWAIT.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    checkOutput("busy_after_rst", 8'(MulDivBusy), 8'd0);

    // Randomized traffic on a narrow register range to provoke collisions.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 99) < 3),
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 15),
                    ($urandom_range(0, 99) < 10));
      runCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
